// File: rtl/game_sequencer.sv
// Game flow controller for the two-lane rhythm datapath: mode FSM, difficulty latch,
// and double-buffered fetching of 64-bit song segments over a req/ack handshake.
module game_sequencer #(
    parameter int          SEG_BEATS  = 32,
    parameter int          CD_BEATS   = 4,
    parameter logic [7:0]  MISS_LIMIT = 8'd20,
    parameter logic [22:0] DIFF_L0    = 23'd6_000_000,
    parameter logic [22:0] DIFF_L1    = 23'd4_000_000,
    parameter logic [22:0] DIFF_L2    = 23'd2_500_000,
    parameter logic [22:0] DIFF_L3    = 23'd1_500_000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic        pause,
    input  logic [1:0]  level,
    input  logic [7:0]  song_len,
    input  logic        beat_clk,
    input  logic [7:0]  num_misses,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [63:0] mem_data,
    output logic [2:0]  mode,
    output logic [22:0] diff,
    output logic [31:0] notes1,
    output logic [31:0] notes2,
    output logic [7:0]  seg_idx,
    output logic        done,
    output logic        failed,
    output logic        underrun
);
    localparam int BW = $clog2(SEG_BEATS) + 1;
    localparam logic [BW-1:0] CD_END  = BW'(CD_BEATS);
    localparam logic [BW-1:0] SEG_END = BW'(SEG_BEATS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CD    = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    logic [2:0]    mode_q, mode_d;
    logic [22:0]   diff_q, diff_d;
    logic [63:0]   notes_q, notes_d;
    logic [7:0]    seg_idx_q, seg_idx_d;
    logic          done_q, done_d, failed_q, failed_d, underrun_q, underrun_d;
    logic          req_q, req_d, discard_q, discard_d, pend_q, pend_d;
    logic [7:0]    addr_q, addr_d, pend_addr_q, pend_addr_d;
    logic [63:0]   back_q, back_d;
    logic          back_valid_q, back_valid_d;
    logic [7:0]    back_seg_q, back_seg_d, play_seg_q, play_seg_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          start_q, pause_q;

    logic        start_edge, pause_edge, accept, want_fetch, last_seg, has_next;
    logic [7:0]  want_addr, seg_inc;
    logic [22:0] level_diff;

    always_comb begin
        start_edge = start & ~start_q;
        pause_edge = pause & ~pause_q;
        accept     = mem_ack & req_q;
        last_seg   = ({1'b0, play_seg_q} + 9'd1) >= {1'b0, song_len};
        has_next   = ({1'b0, back_seg_q} + 9'd1) < {1'b0, song_len};
        seg_inc    = (seg_idx_q == 8'hFF) ? seg_idx_q : seg_idx_q + 8'd1;
        case (level)
            2'd0:    level_diff = DIFF_L0;
            2'd1:    level_diff = DIFF_L1;
            2'd2:    level_diff = DIFF_L2;
            default: level_diff = DIFF_L3;
        endcase

        mode_d       = mode_q;
        diff_d       = diff_q;
        notes_d      = notes_q;
        seg_idx_d    = seg_idx_q;
        done_d       = done_q;
        failed_d     = failed_q;
        underrun_d   = underrun_q;
        req_d        = req_q;
        addr_d       = addr_q;
        discard_d    = discard_q;
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;
        back_d       = back_q;
        back_valid_d = back_valid_q;
        back_seg_d   = back_seg_q;
        play_seg_d   = play_seg_q;
        cnt_d        = cnt_q;
        want_fetch   = 1'b0;
        want_addr    = 8'd0;

        // Acks for a game that has ended or been restarted are consumed and dropped.
        if (accept) begin
            req_d = 1'b0;
            if (discard_q) begin
                discard_d = 1'b0;
            end else if (mode_q == S_CD || mode_q == S_PLAY || mode_q == S_PAUSE) begin
                back_d       = mem_data;
                back_valid_d = 1'b1;
                back_seg_d   = addr_q;
            end
        end

        case (mode_q)
            S_IDLE, S_OVER: begin
                if (start_edge) begin
                    diff_d       = level_diff;
                    done_d       = 1'b0;
                    failed_d     = 1'b0;
                    underrun_d   = 1'b0;
                    back_valid_d = 1'b0;
                    pend_d       = 1'b0;
                    cnt_d        = '0;
                    seg_idx_d    = 8'd0;
                    play_seg_d   = 8'd0;
                    notes_d      = '0;
                    if (req_q && !accept) discard_d = 1'b1;
                    if (song_len == 8'd0) begin
                        mode_d = S_OVER;
                        done_d = 1'b1;
                    end else begin
                        mode_d     = S_CD;
                        want_fetch = 1'b1;
                    end
                end
            end
            S_CD: begin
                if (beat_clk && cnt_q < CD_END) cnt_d = cnt_q + 1'b1;
                if (cnt_q == CD_END && back_valid_q) begin
                    mode_d       = S_PLAY;
                    notes_d      = back_q;
                    back_valid_d = 1'b0;
                    play_seg_d   = back_seg_q;
                    seg_idx_d    = 8'd0;
                    cnt_d        = '0;
                    want_fetch   = has_next;
                    want_addr    = back_seg_q + 8'd1;
                end
            end
            S_PLAY: begin
                if (num_misses >= MISS_LIMIT) begin
                    mode_d   = S_OVER;
                    failed_d = 1'b1;
                    notes_d  = '0;
                    pend_d   = 1'b0;
                end else begin
                    if (beat_clk) begin
                        if (cnt_q == SEG_END) begin
                            cnt_d = '0;
                            if (last_seg) begin
                                mode_d  = S_OVER;
                                done_d  = 1'b1;
                                notes_d = '0;
                                pend_d  = 1'b0;
                            end else if (back_valid_q) begin
                                notes_d      = back_q;
                                back_valid_d = 1'b0;
                                play_seg_d   = back_seg_q;
                                seg_idx_d    = seg_inc;
                                want_fetch   = has_next;
                                want_addr    = back_seg_q + 8'd1;
                            end else begin
                                notes_d    = '0;
                                seg_idx_d  = seg_inc;
                                underrun_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    if (pause_edge && mode_d == S_PLAY) mode_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (pause_edge) mode_d = S_PLAY;
            end
            default: mode_d = S_IDLE;
        endcase

        // One request in flight; a fetch wanted while busy waits in the pending slot.
        if (want_fetch) begin
            if (!req_q) begin
                req_d  = 1'b1;
                addr_d = want_addr;
            end else begin
                pend_d      = 1'b1;
                pend_addr_d = want_addr;
            end
        end else if (pend_q && !req_q && mode_d != S_OVER) begin
            req_d  = 1'b1;
            addr_d = pend_addr_q;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mode_q       <= S_IDLE;
            diff_q       <= DIFF_L0;
            notes_q      <= '0;
            seg_idx_q    <= 8'd0;
            done_q       <= 1'b0;
            failed_q     <= 1'b0;
            underrun_q   <= 1'b0;
            req_q        <= 1'b0;
            addr_q       <= 8'd0;
            discard_q    <= 1'b0;
            pend_q       <= 1'b0;
            pend_addr_q  <= 8'd0;
            back_q       <= '0;
            back_valid_q <= 1'b0;
            back_seg_q   <= 8'd0;
            play_seg_q   <= 8'd0;
            cnt_q        <= '0;
            start_q      <= 1'b0;
            pause_q      <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            diff_q       <= diff_d;
            notes_q      <= notes_d;
            seg_idx_q    <= seg_idx_d;
            done_q       <= done_d;
            failed_q     <= failed_d;
            underrun_q   <= underrun_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            discard_q    <= discard_d;
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            back_q       <= back_d;
            back_valid_q <= back_valid_d;
            back_seg_q   <= back_seg_d;
            play_seg_q   <= play_seg_d;
            cnt_q        <= cnt_d;
            start_q      <= start;
            pause_q      <= pause;
        end
    end

    assign mode     = mode_q;
    assign diff     = diff_q;
    assign notes1   = notes_q[63:32];
    assign notes2   = notes_q[31:0];
    assign seg_idx  = seg_idx_q;
    assign done     = done_q;
    assign failed   = failed_q;
    assign underrun = underrun_q;
    assign mem_req  = req_q;
    assign mem_addr = addr_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: song memory responder plus a linear sequence of
// game scenarios with hand-computed expectations.
module tb_game_sequencer;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0, pause = 1'b0, beat_clk = 1'b0;
    logic [1:0]  level = 2'd0;
    logic [7:0]  song_len = 8'd0, num_misses = 8'd0;
    logic        mem_req, mem_ack;
    logic [7:0]  mem_addr;
    logic [63:0] mem_data;
    logic [2:0]  mode;
    logic [22:0] diff;
    logic [31:0] notes1, notes2;
    logic [7:0]  seg_idx;
    logic        done, failed, underrun;

    int checks = 0;
    int failures = 0;
    logic       hold_on = 1'b0;
    logic [7:0] hold_addr = 8'd0;
    logic       req_seen;

    game_sequencer dut (
        .clk(clk), .n_rst(n_rst), .start(start), .pause(pause), .level(level),
        .song_len(song_len), .beat_clk(beat_clk), .num_misses(num_misses),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .mode(mode), .diff(diff), .notes1(notes1), .notes2(notes2), .seg_idx(seg_idx),
        .done(done), .failed(failed), .underrun(underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] seg_word(input logic [7:0] a);
        return {24'hA5C300, a, 24'h3C5A00, a};
    endfunction

    // Song memory: acks three cycles after a request, optionally holding one address.
    initial begin : responder
        mem_ack = 1'b0;
        mem_data = '0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
                repeat (2) @(posedge clk);
                while (hold_on && mem_addr == hold_addr) @(posedge clk);
                #1;
                if (mem_req === 1'b1) begin
                    mem_ack = 1'b1;
                    mem_data = seg_word(mem_addr);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog run did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic beats(input int n);
        repeat (n) begin
            beat_clk = 1'b1;
            step(1);
            beat_clk = 1'b0;
            step(1);
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pause_pulse();
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        step(1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_mode", 64'(mode), 64'd0);
        chk("rst_diff", 64'(diff), 64'd6_000_000);
        chk("rst_notes", {notes1, notes2}, 64'd0);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_flags", {61'd0, done, failed, underrun}, 64'd0);
        n_rst = 1'b1;
        step(2);

        // Two-segment song at level 2
        song_len = 8'd2;
        level = 2'd2;
        start_pulse();
        chk("n_mode_cd", 64'(mode), 64'd1);
        chk("n_diff", 64'(diff), 64'd2_500_000);
        chk("n_req", 64'(mem_req), 64'd1);
        chk("n_addr", 64'(mem_addr), 64'd0);
        step(1);
        level = 2'd0;
        beats(3);
        chk("n_cd_hold", 64'(mode), 64'd1);
        beats(1);
        chk("n_mode_play", 64'(mode), 64'd2);
        chk("n_word0", {notes1, notes2}, seg_word(8'd0));
        chk("n_seg0", 64'(seg_idx), 64'd0);
        beats(31);
        chk("n_word0_end", {notes1, notes2}, seg_word(8'd0));
        beats(1);
        chk("n_word1", {notes1, notes2}, seg_word(8'd1));
        chk("n_seg1", 64'(seg_idx), 64'd1);
        chk("n_diff_held", 64'(diff), 64'd2_500_000);
        beats(31);
        chk("n_still_play", 64'(mode), 64'd2);
        beats(1);
        chk("n_over", 64'(mode), 64'd4);
        chk("n_done", 64'(done), 64'd1);
        chk("n_notes_zero", {notes1, notes2}, 64'd0);

        // Miss limit reached on a boundary beat (restart from OVER)
        song_len = 8'd3;
        level = 2'd1;
        start_pulse();
        chk("f_restart", 64'(mode), 64'd1);
        chk("f_diff", 64'(diff), 64'd4_000_000);
        chk("f_done_clr", 64'(done), 64'd0);
        step(1);
        beats(4);
        beats(31);
        chk("f_play", 64'(mode), 64'd2);
        num_misses = 8'd20;
        beat_clk = 1'b1;
        step(1);
        beat_clk = 1'b0;
        num_misses = 8'd0;
        chk("f_over", 64'(mode), 64'd4);
        chk("f_failed", 64'(failed), 64'd1);
        chk("f_not_done", 64'(done), 64'd0);
        chk("f_seg_held", 64'(seg_idx), 64'd0);
        step(1);

        // Underrun: segment 1 withheld until 40 beats in
        hold_addr = 8'd1;
        hold_on = 1'b1;
        song_len = 8'd3;
        level = 2'd3;
        start_pulse();
        chk("u_failed_clr", 64'(failed), 64'd0);
        chk("u_diff", 64'(diff), 64'd1_500_000);
        step(1);
        beats(4);
        chk("u_word0", {notes1, notes2}, seg_word(8'd0));
        beats(32);
        chk("u_notes_zero", {notes1, notes2}, 64'd0);
        chk("u_flag", 64'(underrun), 64'd1);
        chk("u_seg1", 64'(seg_idx), 64'd1);
        chk("u_play", 64'(mode), 64'd2);
        beats(8);
        hold_on = 1'b0;
        beats(23);
        chk("u_zero_end", {notes1, notes2}, 64'd0);
        beats(1);
        chk("u_word1", {notes1, notes2}, seg_word(8'd1));
        chk("u_seg2", 64'(seg_idx), 64'd2);
        beats(32);
        chk("u_word2", {notes1, notes2}, seg_word(8'd2));
        chk("u_play2", 64'(mode), 64'd2);
        chk("u_sticky", 64'(underrun), 64'd1);
        beats(32);
        chk("u_over", 64'(mode), 64'd4);
        chk("u_done", 64'(done), 64'd1);

        // Pause for 50 beats after beat 10
        song_len = 8'd2;
        level = 2'd0;
        start_pulse();
        chk("p_underrun_clr", 64'(underrun), 64'd0);
        step(1);
        beats(4);
        beats(10);
        pause_pulse();
        chk("p_paused", 64'(mode), 64'd3);
        beats(50);
        chk("p_seg_held", 64'(seg_idx), 64'd0);
        chk("p_notes_held", {notes1, notes2}, seg_word(8'd0));
        chk("p_still_paused", 64'(mode), 64'd3);
        pause_pulse();
        chk("p_resumed", 64'(mode), 64'd2);
        beats(21);
        chk("p_seg_before", 64'(seg_idx), 64'd0);
        beats(1);
        chk("p_seg_after", 64'(seg_idx), 64'd1);
        chk("p_word1", {notes1, notes2}, seg_word(8'd1));

        // Asynchronous reset mid-PLAY, checked before any clock edge
        n_rst = 1'b0;
        #1;
        chk("ar_mode", 64'(mode), 64'd0);
        chk("ar_notes", {notes1, notes2}, 64'd0);
        chk("ar_req", 64'(mem_req), 64'd0);
        chk("ar_diff", 64'(diff), 64'd6_000_000);
        #1;
        n_rst = 1'b1;
        step(2);

        // Empty song, then restart
        song_len = 8'd0;
        req_seen = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("e_over", 64'(mode), 64'd4);
        chk("e_done", 64'(done), 64'd1);
        repeat (6) begin
            req_seen = req_seen | mem_req;
            step(1);
        end
        chk("e_no_req", 64'(req_seen), 64'd0);
        song_len = 8'd2;
        start_pulse();
        chk("e_restart", 64'(mode), 64'd1);
        chk("e_restart_req", 64'(mem_req), 64'd1);
        chk("e_done_clr", 64'(done), 64'd0);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
